// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch -- instruction fetch stage of the single-clock CPU.
//
// Keeps the program counter, reads a synchronous-read instruction memory and
// presents each fetched 16-bit instruction in a registered output, together
// with the address it came from. A one-entry skid register catches the read
// that is already in flight when a downstream stall begins, so no instruction
// is lost and there is no bubble when the stall ends. A redirect (branch or
// jump taken) loads a new PC and discards anything in flight.
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   stall        in   downstream not accepting; freezes outputs and PC
//   redirect     in   load redirect_pc into the PC; wins over stall
//   redirect_pc  in   [ADDR_W-1:0] branch/jump target
//   imem_req     out  instruction-memory read strobe
//   imem_addr    out  [ADDR_W-1:0] read address (the PC register)
//   imem_rdata   in   [15:0] read data, valid the cycle after imem_req
//   instr        out  [15:0] registered fetched instruction
//   opcode       out  [1:0]  instr[15:14]
//   immediate    out  [13:0] instr[13:0], feeds sign_extend.immediate_in
//   pc_out       out  [ADDR_W-1:0] address instr was fetched from
//   instr_valid  out  instr/pc_out hold a valid instruction
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int unsigned          ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       instr,
  output logic [1:0]        opcode,
  output logic [13:0]       immediate,
  output logic [ADDR_W-1:0] pc_out,
  output logic              instr_valid
);

  // Program counter and the read currently in flight.
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] pending_pc_q, pending_pc_d;

  // Output registers.
  logic [15:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic              instr_valid_q, instr_valid_d;

  // Skid entry holding the read that completed during a stall.
  logic [15:0]       skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
  logic              skid_valid_q, skid_valid_d;

  logic              issue;

  // No request while stalled or redirecting. Gating with rst_n keeps the
  // strobe low for as long as reset is held.
  assign issue     = rst_n && !stall && !redirect;
  assign imem_req  = issue;
  assign imem_addr = pc_q;

  assign instr       = instr_q;
  assign opcode      = instr_q[15:14];
  assign immediate   = instr_q[13:0];
  assign pc_out      = pc_out_q;
  assign instr_valid = instr_valid_q;

  always_comb begin
    // NOTE: every variable gets a hold default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    pc_d          = pc_q;
    pending_d     = 1'b0;
    pending_pc_d  = pending_pc_q;
    instr_d       = instr_q;
    pc_out_d      = pc_out_q;
    instr_valid_d = instr_valid_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    skid_valid_d  = skid_valid_q;

    if (redirect) begin
      // Drop the in-flight read and any skid entry; instr/pc_out keep their
      // stale contents but are marked invalid.
      pc_d          = redirect_pc;
      skid_valid_d  = 1'b0;
      instr_valid_d = 1'b0;
    end else if (stall) begin
      // Outputs and PC frozen. The read issued last cycle lands now and would
      // be lost, so park it in the skid register.
      if (pending_q) begin
        skid_instr_d = imem_rdata;
        skid_pc_d    = pending_pc_q;
        skid_valid_d = 1'b1;
      end
    end else begin
      // The skid entry is older than any pending read, so it goes first. The
      // two are never both set here because nothing is issued while stalled.
      if (skid_valid_q) begin
        instr_d       = skid_instr_q;
        pc_out_d      = skid_pc_q;
        instr_valid_d = 1'b1;
        skid_valid_d  = 1'b0;
      end else if (pending_q) begin
        instr_d       = imem_rdata;
        pc_out_d      = pending_pc_q;
        instr_valid_d = 1'b1;
      end else begin
        instr_valid_d = 1'b0;
      end
      pc_d         = pc_q + ADDR_W'(1);  // all-ones wraps to zero
      pending_d    = 1'b1;
      pending_pc_d = pc_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the skid and pending-address registers are reset as well even
      // though their valid bits already qualify them; this keeps every output
      // and internal value deterministic straight out of reset.
      pc_q          <= RESET_PC;
      pending_q     <= 1'b0;
      pending_pc_q  <= '0;
      instr_q       <= '0;
      pc_out_q      <= '0;
      instr_valid_q <= 1'b0;
      skid_instr_q  <= '0;
      skid_pc_q     <= '0;
      skid_valid_q  <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      pending_q     <= pending_d;
      pending_pc_q  <= pending_pc_d;
      instr_q       <= instr_d;
      pc_out_q      <= pc_out_d;
      instr_valid_q <= instr_valid_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
      skid_valid_q  <= skid_valid_d;
    end
  end

endmodule
